spi_input_frontend: RTL
=======================

Name: spi_input_frontend

Overview:
- Upstream stage of the SPI slave control FSM. Takes the three asynchronous pad inputs SCLK, CS and MOSI and conditions each one in the system clock domain.
- Conditioning per channel: 2-flop synchronizer, then debounce, then single-cycle edge detection.
- Delivers clean levels and one-cycle edge pulses. The control FSM and the shift registers use these pulses as serial clock enables and chip-select start/stop events.

Parameters:
- WAIT_TIME, 3, number of consecutive extra cycles the synchronized input must differ from the conditioned value before the conditioned value updates.
- CNT_WIDTH, 3, debounce counter width. Must satisfy 2^CNT_WIDTH > WAIT_TIME; elaboration error otherwise.
- SCLK_IDLE, 1'b0, reset/idle level of the SCLK channel (CPOL).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sclk_raw  in  1  asynchronous SCLK pad.
- cs_raw  in  1  asynchronous chip select pad, active low.
- mosi_raw  in  1  asynchronous MOSI pad.
- sclk_cond  out  1  conditioned SCLK level.
- sclk_posedge  out  1  one-cycle pulse on conditioned SCLK 0->1.
- sclk_negedge  out  1  one-cycle pulse on conditioned SCLK 1->0.
- cs_cond  out  1  conditioned CS level.
- cs_posedge  out  1  one-cycle pulse on CS deassert (0->1).
- cs_negedge  out  1  one-cycle pulse on CS assert (1->0).
- mosi_cond  out  1  conditioned MOSI level.

Behaviour:
- Reset values (reset_n=0 at a clk edge): per-channel idle values are SCLK=SCLK_IDLE, CS=1, MOSI=0.
  - Both synchronizer flops load the idle value.
  - Conditioned value = idle value; counter = 0; all edge pulses = 0.
  - Reset mid-transition discards pending counts. No edge pulse is generated by reset itself.
- Per-channel pipeline, each edge (not in reset):
  - s0 <= raw; s1 <= s0.
  - If s1 == cond: cnt <= 0.
  - Else if cnt == WAIT_TIME: cond <= s1, cnt <= 0, and the matching posedge/negedge register <= 1.
  - Else: cnt <= cnt+1.
  - Edge pulse registers default to 0 every cycle, so each pulse lasts exactly one cycle, coincident with the cond change.
- Latency: raw level first sampled by edge n and held stable -> cond and pulse change after edge n+WAIT_TIME+2 (5 edges at the default).
- Glitch rejection: if s1 returns to cond before cnt reaches WAIT_TIME, the counter clears, cond is unchanged and no pulse is issued. Any s1 excursion of at most WAIT_TIME cycles is rejected.
- Counter never wraps: its maximum value is WAIT_TIME.
- posedge and negedge of the same channel are never asserted together.
- Channels are fully independent. Simultaneous transitions on several channels produce pulses in the same cycle when their latencies match.
- MOSI has no edge outputs. The downstream stage samples mosi_cond on sclk_posedge.
- System constraint: each SCLK half-period must be at least WAIT_TIME+3 clk cycles, otherwise SCLK edges are lost. Verification checks this as a documented limit, not as a bug.

Decomposition:
- Shared include spi_defines.v holds:
  - `CSON / `CSOFF (shared with the control FSM);
  - idle-level constants for MOSI;
  - default WAIT_TIME and CNT_WIDTH.
- One natural sub-module: input_conditioner (single channel).
  - Parameters: WAIT_TIME, CNT_WIDTH, IDLE.
  - Ports: clk, reset_n, noisysignal, conditioned, positiveedge, negativeedge.
  - Instantiated three times. The MOSI instance leaves its edge outputs unconnected.

Test Plan:
- Reset hold: reset_n=0 for 4 cycles with all raw inputs toggling -> sclk_cond=0, cs_cond=1, mosi_cond=0, all pulses 0 throughout and on the first cycle after release.
- Clean CS assert: cs_raw 1->0 sampled at edge 10 and held -> cs_cond=0 and cs_negedge=1 during cycle after edge 15 only; no cs_posedge; the other channels are unchanged.
- SCLK glitch: sclk_raw high for exactly 3 cycles, then low -> sclk_cond stays 0, no pulses. sclk_raw high for 4 cycles -> one sclk_posedge, then after release one sclk_negedge; pulses are 4 cycles apart.
- Serial byte: 8 SCLK periods of 16 clk cycles with MOSI pattern 0xA5 set up on negedges -> exactly 8 sclk_posedge pulses; mosi_cond sampled at each reads 1,0,1,0,0,1,0,1.
- Reset mid-debounce: cs_raw falls; reset_n=0 asserted after 3 cycles for 1 cycle while cs_raw stays 0 -> no cs_negedge during/after reset until a fresh WAIT_TIME+2 latency elapses. That happens 5 cycles after the first post-reset sample, then a single cs_negedge pulse.
- Simultaneous channels: cs_raw 1->0 and sclk_raw 0->1 sampled at the same edge -> cs_negedge and sclk_posedge asserted in the same cycle, each for exactly one cycle.

Source files
------------

// File: rtl/spi_input_frontend_pkg.sv
// Shared constants for the SPI slave front end and control FSM.
// Chip-select levels, channel idle levels and default debounce sizing.
package spi_input_frontend_pkg;

    localparam logic CSON      = 1'b0;
    localparam logic CSOFF     = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    localparam int unsigned DEFAULT_WAIT_TIME = 3;
    localparam int unsigned DEFAULT_CNT_WIDTH = 3;

    // True when a counter of cnt_width bits can hold wait_time.
    function automatic bit cnt_fits(input int unsigned wait_time, input int unsigned cnt_width);
        return (64'd1 << cnt_width) > 64'(wait_time);
    endfunction

endpackage

// File: rtl/input_conditioner.sv
// Single-channel pad conditioner: 2-flop synchronizer, debounce counter and
// one-cycle edge pulses coincident with the conditioned level change.
module input_conditioner
    import spi_input_frontend_pkg::*;
#(
    parameter int unsigned WAIT_TIME = DEFAULT_WAIT_TIME,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter logic        IDLE      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    if (!cnt_fits(WAIT_TIME, CNT_WIDTH)) begin : gen_bad_cnt_width
        $error("input_conditioner: CNT_WIDTH too narrow for WAIT_TIME");
    end

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(WAIT_TIME);

    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 cond_q, cond_d;
    logic                 pos_q, pos_d;
    logic                 neg_q, neg_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        s0_d   = noisysignal;
        s1_d   = s0_q;
        cond_d = cond_q;
        cnt_d  = cnt_q;
        pos_d  = 1'b0;
        neg_d  = 1'b0;
        if (s1_q == cond_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // Synchronized level has disagreed for WAIT_TIME+1 edges: accept it.
            cond_d = s1_q;
            cnt_d  = '0;
            pos_d  = s1_q;
            neg_d  = ~s1_q;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0_q   <= IDLE;
            s1_q   <= IDLE;
            cond_q <= IDLE;
            cnt_q  <= '0;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            cond_q <= cond_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;

endmodule

// File: rtl/spi_input_frontend.sv
// SPI slave input front end: conditions SCLK, CS and MOSI pads into clean
// levels and edge pulses for the control FSM and shift registers.
module spi_input_frontend
    import spi_input_frontend_pkg::*;
#(
    parameter int unsigned WAIT_TIME = DEFAULT_WAIT_TIME,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter logic        SCLK_IDLE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_raw,
    input  logic cs_raw,
    input  logic mosi_raw,
    output logic sclk_cond,
    output logic sclk_posedge,
    output logic sclk_negedge,
    output logic cs_cond,
    output logic cs_posedge,
    output logic cs_negedge,
    output logic mosi_cond
);

    // MOSI is sampled on sclk_posedge downstream, so its edges go nowhere.
    logic mosi_pos_unused;
    logic mosi_neg_unused;

    input_conditioner #(
        .WAIT_TIME(WAIT_TIME),
        .CNT_WIDTH(CNT_WIDTH),
        .IDLE     (SCLK_IDLE)
    ) u_sclk (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisysignal (sclk_raw),
        .conditioned (sclk_cond),
        .positiveedge(sclk_posedge),
        .negativeedge(sclk_negedge)
    );

    input_conditioner #(
        .WAIT_TIME(WAIT_TIME),
        .CNT_WIDTH(CNT_WIDTH),
        .IDLE     (CSOFF)
    ) u_cs (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisysignal (cs_raw),
        .conditioned (cs_cond),
        .positiveedge(cs_posedge),
        .negativeedge(cs_negedge)
    );

    input_conditioner #(
        .WAIT_TIME(WAIT_TIME),
        .CNT_WIDTH(CNT_WIDTH),
        .IDLE     (MOSI_IDLE)
    ) u_mosi (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisysignal (mosi_raw),
        .conditioned (mosi_cond),
        .positiveedge(mosi_pos_unused),
        .negativeedge(mosi_neg_unused)
    );

endmodule
